// File: rtl/constraint_check_pkg.sv
// Shared types for the pipelined constraint checker: opcode encoding and the
// per-slot configuration record held in the runtime-programmable table.
package constraint_check_pkg;

    localparam int OPC_W = 3;
    // Field widths of a stored slot; they cover up to 16 variables of up to 32 bits.
    localparam int SEL_W = 4;
    localparam int IMM_W = 32;

    typedef enum logic [OPC_W-1:0] {
        OP_OR       = 3'd0,
        OP_XNOR     = 3'd1,
        OP_ADD      = 3'd2,
        OP_NADD     = 3'd3,
        OP_LAND     = 3'd4,
        OP_NEQ_LAND = 3'd5,
        OP_SUB      = 3'd6,
        OP_TRUE     = 3'd7
    } op_e;

    typedef struct packed {
        logic             en;
        op_e              op;
        logic [SEL_W-1:0] a_idx;
        logic [SEL_W-1:0] b_idx;
        logic [IMM_W-1:0] imm;
    } slot_cfg_t;

    localparam slot_cfg_t SLOT_RESET = '{en: 1'b0, op: OP_TRUE, a_idx: '0, b_idx: '0, imm: '0};

endpackage

// File: rtl/constraint_check_pipe_slot_eval.sv
// Combinational evaluation of one constraint slot: computes r = f(A, B, imm)
// and reports pass when any bit of r is set.
module constraint_slot_eval
    import constraint_check_pkg::*;
#(
    parameter int VAR_W = 32
) (
    input  op_e              op,
    input  logic [VAR_W-1:0] a,
    input  logic [VAR_W-1:0] b,
    input  logic [VAR_W-1:0] imm,
    output logic             pass
);

    logic [VAR_W-1:0] r;

    always_comb begin
        r = '0;
        case (op)
            OP_OR:       r = a | b | imm;
            OP_XNOR:     r = (~a) ^ b;
            OP_ADD:      r = a + b + imm;
            OP_NADD:     r = ~(a + b);
            OP_LAND:     r = VAR_W'((a != '0) && (b != '0));
            OP_NEQ_LAND: r = VAR_W'((a != b) && (a != '0));
            OP_SUB:      r = a - b - imm;
            default:     r = VAR_W'(1);
        endcase
        pass = |r;
    end

endmodule

// File: rtl/constraint_check_pipe.sv
// Two-stage valid/ready constraint checker: S1 latches per-slot operands,
// S2 latches the fail mask and pass bit; delivered results feed statistics.
module constraint_check_pipe
    import constraint_check_pkg::*;
#(
    parameter int NUM_VARS = 10,
    parameter int VAR_W    = 32,
    parameter int NUM_CONS = 10,
    parameter int CNT_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    output logic                        cfg_ready,
    input  logic [$clog2(NUM_CONS)-1:0] cfg_idx,
    input  logic                        cfg_en,
    input  logic [OPC_W-1:0]            cfg_op,
    input  logic [$clog2(NUM_VARS)-1:0] cfg_a,
    input  logic [$clog2(NUM_VARS)-1:0] cfg_b,
    input  logic [VAR_W-1:0]            cfg_imm,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_VARS*VAR_W-1:0]   in_sample,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_pass,
    output logic [NUM_CONS-1:0]         out_fail_mask,
    input  logic                        clr_stats,
    output logic [CNT_W-1:0]            cnt_checked,
    output logic [CNT_W-1:0]            cnt_passed,
    output logic                        first_fail_vld,
    output logic [NUM_CONS-1:0]         first_fail_mask,
    output logic [CNT_W-1:0]            first_fail_seq
);

    localparam int CI_W = $clog2(NUM_CONS);

    slot_cfg_t        cfg_tbl [NUM_CONS];
    slot_cfg_t        new_slot;
    logic             cfg_acc;

    logic             s1_valid;
    logic [VAR_W-1:0] s1_a   [NUM_CONS];
    logic [VAR_W-1:0] s1_b   [NUM_CONS];
    logic [VAR_W-1:0] s1_imm [NUM_CONS];
    op_e              s1_op  [NUM_CONS];
    logic [NUM_CONS-1:0] s1_en;

    logic [NUM_CONS-1:0] slot_pass;
    logic [NUM_CONS-1:0] fail_nxt;
    logic                s2_adv;
    logic                xfer;

    // Out-of-range variable selects read as zero rather than aliasing.
    function automatic logic [VAR_W-1:0] pick(input logic [NUM_VARS*VAR_W-1:0] smp,
                                              input logic [SEL_W-1:0] idx);
        logic [VAR_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NUM_VARS; i++) begin
            if (idx == SEL_W'(i)) v = smp[i*VAR_W +: VAR_W];
        end
        return v;
    endfunction

    assign s2_adv    = !out_valid || out_ready;
    assign in_ready  = !s1_valid || s2_adv;
    assign cfg_ready = !s1_valid && !out_valid;
    assign cfg_acc   = cfg_we && cfg_ready;
    assign xfer      = out_valid && out_ready;

    always_comb begin
        new_slot       = SLOT_RESET;
        new_slot.en    = cfg_en;
        new_slot.op    = op_e'(cfg_op);
        new_slot.a_idx = SEL_W'(cfg_a);
        new_slot.b_idx = SEL_W'(cfg_b);
        new_slot.imm   = IMM_W'(cfg_imm);
    end

    // Indices outside the table match no slot, so such writes fall away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_CONS; k++) cfg_tbl[k] <= SLOT_RESET;
        end else if (cfg_acc) begin
            for (int unsigned k = 0; k < NUM_CONS; k++) begin
                if (cfg_idx == CI_W'(k)) cfg_tbl[k] <= new_slot;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_en    <= '0;
            for (int unsigned k = 0; k < NUM_CONS; k++) begin
                s1_a[k]   <= '0;
                s1_b[k]   <= '0;
                s1_imm[k] <= '0;
                s1_op[k]  <= OP_TRUE;
            end
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                for (int unsigned k = 0; k < NUM_CONS; k++) begin
                    s1_a[k]   <= pick(in_sample, cfg_tbl[k].a_idx);
                    s1_b[k]   <= pick(in_sample, cfg_tbl[k].b_idx);
                    s1_imm[k] <= VAR_W'(cfg_tbl[k].imm);
                    s1_op[k]  <= cfg_tbl[k].op;
                    s1_en[k]  <= cfg_tbl[k].en;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_CONS; k++) begin : g_slot
        constraint_slot_eval #(
            .VAR_W(VAR_W)
        ) u_eval (
            .op  (s1_op[k]),
            .a   (s1_a[k]),
            .b   (s1_b[k]),
            .imm (s1_imm[k]),
            .pass(slot_pass[k])
        );
    end

    always_comb begin
        fail_nxt = s1_en & ~slot_pass;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_pass      <= 1'b0;
            out_fail_mask <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_fail_mask <= fail_nxt;
                out_pass      <= ~|fail_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_checked     <= '0;
            cnt_passed      <= '0;
            first_fail_vld  <= 1'b0;
            first_fail_mask <= '0;
            first_fail_seq  <= '0;
        end else if (clr_stats) begin
            cnt_checked     <= '0;
            cnt_passed      <= '0;
            first_fail_vld  <= 1'b0;
            first_fail_mask <= '0;
            first_fail_seq  <= '0;
        end else if (xfer) begin
            if (cnt_checked != '1) cnt_checked <= cnt_checked + 1'b1;
            if (out_pass && (cnt_passed != '1)) cnt_passed <= cnt_passed + 1'b1;
            if (!out_pass && !first_fail_vld) begin
                first_fail_vld  <= 1'b1;
                first_fail_mask <= out_fail_mask;
                first_fail_seq  <= cnt_checked;
            end
        end
    end

endmodule

// File: tb/tb_constraint_check_pipe.sv
// Randomised bench for constraint_check_pipe against a queue-based model of
// the checking rules, delivery order and statistics.
module tb_constraint_check_pipe;

    localparam int NV   = 10;
    localparam int VW   = 32;
    localparam int NC   = 10;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we, cfg_ready, cfg_en;
    logic [3:0]        cfg_idx, cfg_a, cfg_b;
    logic [2:0]        cfg_op;
    logic [VW-1:0]     cfg_imm;
    logic              in_valid, in_ready;
    logic [NV*VW-1:0]  in_sample;
    logic              out_valid, out_ready, out_pass;
    logic [NC-1:0]     out_fail_mask;
    logic              clr_stats;
    logic [CW-1:0]     cnt_checked, cnt_passed, first_fail_seq;
    logic              first_fail_vld;
    logic [NC-1:0]     first_fail_mask;

    constraint_check_pipe #(
        .NUM_VARS(NV),
        .VAR_W   (VW),
        .NUM_CONS(NC),
        .CNT_W   (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_we         (cfg_we),
        .cfg_ready      (cfg_ready),
        .cfg_idx        (cfg_idx),
        .cfg_en         (cfg_en),
        .cfg_op         (cfg_op),
        .cfg_a          (cfg_a),
        .cfg_b          (cfg_b),
        .cfg_imm        (cfg_imm),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sample      (in_sample),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pass       (out_pass),
        .out_fail_mask  (out_fail_mask),
        .clr_stats      (clr_stats),
        .cnt_checked    (cnt_checked),
        .cnt_passed     (cnt_passed),
        .first_fail_vld (first_fail_vld),
        .first_fail_mask(first_fail_mask),
        .first_fail_seq (first_fail_seq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            en;
        int            op;
        int            a;
        int            b;
        logic [VW-1:0] imm;
    } mcfg_t;

    mcfg_t         mcfg [NC];
    logic [NC:0]   pend_q[$], done_q[$], obs_q[$];
    int            m_chk, m_pas, m_ffs;
    bit            m_ffv;
    logic [NC-1:0] m_ffm;
    int            n_chk, n_err;

    bit            last_acc;
    logic          smp_in_ready, smp_cfg_ready, smp_out_valid;
    logic [NC:0]   smp_out;

    // A slot passes when r = f(A,B,imm) has any bit set; each case states that directly.
    function automatic bit op_ok(input int op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                                 input logic [VW-1:0] imm);
        logic [VW-1:0] t;
        case (op)
            0: return (a != 0) || (b != 0) || (imm != 0);
            1: return a != ~b;
            2: begin t = a + b + imm; return t != 0; end
            3: begin t = a + b; return t != {VW{1'b1}}; end
            4: return (a != 0) && (b != 0);
            5: return (a != b) && (a != 0);
            6: begin t = b + imm; return a != t; end
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [NC:0] model_eval(input logic [NV*VW-1:0] s);
        logic [NC-1:0] m;
        m = '0;
        for (int k = 0; k < NC; k++) begin
            if (mcfg[k].en && !op_ok(mcfg[k].op, s[mcfg[k].a*VW +: VW], s[mcfg[k].b*VW +: VW], mcfg[k].imm))
                m[k] = 1'b1;
        end
        return {(m == '0), m};
    endfunction

    function automatic logic [NV*VW-1:0] rand_sample();
        logic [NV*VW-1:0] s;
        logic [VW-1:0]    v;
        s = '0;
        for (int i = 0; i < NV; i++) begin
            case ($urandom_range(0, 4))
                0: v = '0;
                1: v = '1;
                2: v = (i > 0) ? s[(i-1)*VW +: VW] : 32'd1;
                default: v = $urandom();
            endcase
            s[i*VW +: VW] = v;
        end
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NC; k++) mcfg[k] = '{en: 1'b0, op: 7, a: 0, b: 0, imm: '0};
        pend_q.delete(); done_q.delete(); obs_q.delete();
        m_chk = 0; m_pas = 0; m_ffs = 0; m_ffv = 1'b0; m_ffm = '0;
    endtask

    // One clock: sample handshakes mid-cycle, advance the model, then cross the edge.
    task automatic tick();
        logic [NC:0] e, ex;
        bit acc, xfer, wr;
        #1;
        acc = in_valid && in_ready;
        xfer = out_valid && out_ready;
        wr = cfg_we && (pend_q.size() == 0) && (cfg_idx < NC);
        smp_in_ready = in_ready;
        smp_cfg_ready = cfg_ready;
        smp_out_valid = out_valid;
        smp_out = {out_pass, out_fail_mask};
        e = model_eval(in_sample);
        if (xfer) begin
            if (pend_q.size() > 0) ex = pend_q.pop_front();
            else ex = 'x;
            obs_q.push_back(smp_out);
            done_q.push_back(ex);
            if (!clr_stats) begin
                if (!m_ffv && ex[NC] === 1'b0) begin
                    m_ffv = 1'b1; m_ffm = ex[NC-1:0]; m_ffs = m_chk;
                end
                if (m_chk < CMAX) m_chk++;
                if (ex[NC] === 1'b1 && m_pas < CMAX) m_pas++;
            end
        end
        if (clr_stats) begin
            m_chk = 0; m_pas = 0; m_ffs = 0; m_ffv = 1'b0; m_ffm = '0;
        end
        if (wr) mcfg[cfg_idx] = '{en: cfg_en, op: int'(cfg_op), a: int'(cfg_a), b: int'(cfg_b), imm: cfg_imm};
        if (acc) pend_q.push_back(e);
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input int idx, input bit en, input int op, input int a, input int b,
                             input logic [VW-1:0] imm);
        cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_en = en; cfg_op = 3'(op);
        cfg_a = 4'(a); cfg_b = 4'(b); cfg_imm = imm;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic drain(output bit timed_out);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && pend_q.size() > 0; c++) tick();
        tick();
        timed_out = (pend_q.size() != 0);
    endtask

    task automatic test_reset();
        n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_chk++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
        n_chk++; if (cnt_checked !== 4'd0 || cnt_passed !== 4'd0) begin n_err++; $display("FAIL reset_counters got %0d/%0d want 0/0", cnt_checked, cnt_passed); end
        n_chk++; if (first_fail_vld !== 1'b0) begin n_err++; $display("FAIL reset_first_fail got %b want 0", first_fail_vld); end
        in_sample = rand_sample(); in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL latency_early got %b want 0", out_valid); end
        tick();
        n_chk++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL latency_two got %b want 1", out_valid); end
        n_chk++; if ({out_pass, out_fail_mask} !== {1'b1, 10'b0}) begin n_err++; $display("FAIL reset_result got %b/%b want 1/0", out_pass, out_fail_mask); end
        tick();
        n_chk++; if (cnt_checked !== 4'd1 || cnt_passed !== 4'd1) begin n_err++; $display("FAIL reset_stats got %0d/%0d want 1/1", cnt_checked, cnt_passed); end
    endtask

    task automatic test_opcode();
        logic [NV*VW-1:0] s;
        bit to;
        write_cfg(0, 1'b1, 2, 0, 1, '0);
        clr_stats = 1'b1; tick(); clr_stats = 1'b0;
        obs_q.delete(); done_q.delete();
        s = rand_sample(); s[31:0] = 32'hFFFF_FFFF; s[63:32] = 32'd1;
        in_sample = s; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        s[63:32] = 32'd2; in_sample = s;
        tick();
        drain(to);
        n_chk++; if (to || obs_q.size() != 2) begin n_err++; $display("FAIL add_count got %0d want 2", obs_q.size()); end
        n_chk++; if (obs_q[0] !== {1'b0, 10'b1}) begin n_err++; $display("FAIL add_wrap got %b want %b", obs_q[0], {1'b0, 10'b1}); end
        n_chk++; if (obs_q[1] !== {1'b1, 10'b0}) begin n_err++; $display("FAIL add_pass got %b want %b", obs_q[1], {1'b1, 10'b0}); end
        n_chk++; if (first_fail_vld !== 1'b1 || first_fail_mask !== 10'b1 || first_fail_seq !== 4'd0)
            begin n_err++; $display("FAIL add_first_fail got %b/%b/%0d want 1/0000000001/0", first_fail_vld, first_fail_mask, first_fail_seq); end
        n_chk++; if (cnt_checked !== 4'd2 || cnt_passed !== 4'd1) begin n_err++; $display("FAIL add_stats got %0d/%0d want 2/1", cnt_checked, cnt_passed); end
    endtask

    task automatic test_backpressure();
        logic [NV*VW-1:0] smp [5];
        logic [NC:0] prev;
        bit hold, to;
        int idx;
        for (int k = 1; k < 4; k++) write_cfg(k, 1'b1, $urandom_range(0, 7), $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 3));
        clr_stats = 1'b1; tick(); clr_stats = 1'b0;
        obs_q.delete(); done_q.delete();
        foreach (smp[i]) smp[i] = rand_sample();
        idx = 0; hold = 1'b0; prev = '0;
        for (int c = 0; c < 40; c++) begin
            out_ready = (c >= 3);
            in_valid = (idx < 5);
            in_sample = smp[idx < 5 ? idx : 0];
            tick();
            if (c == 2) begin
                n_chk++; if (smp_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_full got %b want 0", smp_in_ready); end
            end
            if (hold) begin
                n_chk++; if (smp_out !== prev) begin n_err++; $display("FAIL bp_stable got %b want %b", smp_out, prev); end
            end
            hold = smp_out_valid && !out_ready;
            prev = smp_out;
            if (last_acc) idx++;
            if (idx == 5 && pend_q.size() == 0) break;
        end
        in_valid = 1'b0;
        drain(to);
        n_chk++; if (to || idx != 5 || obs_q.size() != 5) begin n_err++; $display("FAIL bp_count got %0d want 5", obs_q.size()); end
        foreach (obs_q[i]) begin
            n_chk++; if (obs_q[i] !== done_q[i]) begin n_err++; $display("FAIL bp_result[%0d] got %b want %b", i, obs_q[i], done_q[i]); end
        end
        n_chk++; if (cnt_checked !== 4'd5) begin n_err++; $display("FAIL bp_cnt_checked got %0d want 5", cnt_checked); end
    endtask

    task automatic test_cfg_gating();
        logic [NV*VW-1:0] s;
        bit to;
        write_cfg(2, 1'b1, 4, 3, 4, '0);
        obs_q.delete(); done_q.delete();
        in_sample = rand_sample(); in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        write_cfg(2, 1'b0, 7, 0, 0, '0);
        n_chk++; if (smp_cfg_ready !== 1'b0) begin n_err++; $display("FAIL gate_busy_cfg_ready got %b want 0", smp_cfg_ready); end
        drain(to);
        s = rand_sample(); s[3*VW +: VW] = '0;
        in_sample = s; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        drain(to);
        cfg_we = 1'b1; cfg_idx = 4'd2; cfg_en = 1'b0; cfg_op = 3'd7; cfg_a = '0; cfg_b = '0; cfg_imm = '0;
        in_valid = 1'b1;
        tick();
        cfg_we = 1'b0;
        n_chk++; if (smp_cfg_ready !== 1'b1 || last_acc !== 1'b1) begin n_err++; $display("FAIL gate_idle_accept got %b/%b want 1/1", smp_cfg_ready, last_acc); end
        tick();
        drain(to);
        n_chk++; if (to || obs_q.size() != 4) begin n_err++; $display("FAIL gate_count got %0d want 4", obs_q.size()); end
        n_chk++; if (obs_q[1][2] !== 1'b1) begin n_err++; $display("FAIL gate_ignored_write got %b want 1", obs_q[1][2]); end
        n_chk++; if (obs_q[2][2] !== 1'b1) begin n_err++; $display("FAIL gate_same_cycle_old got %b want 1", obs_q[2][2]); end
        n_chk++; if (obs_q[3][2] !== 1'b0) begin n_err++; $display("FAIL gate_next_new got %b want 0", obs_q[3][2]); end
        foreach (obs_q[i]) begin
            n_chk++; if (obs_q[i] !== done_q[i]) begin n_err++; $display("FAIL gate_result[%0d] got %b want %b", i, obs_q[i], done_q[i]); end
        end
    endtask

    task automatic test_saturation();
        int sent;
        bit to;
        for (int k = 0; k < NC; k++) write_cfg(k, 1'b0, 7, 0, 0, '0);
        clr_stats = 1'b1; tick(); clr_stats = 1'b0;
        sent = 0; out_ready = 1'b1;
        for (int c = 0; c < 60 && sent < 20; c++) begin
            in_valid = 1'b1; in_sample = rand_sample();
            tick();
            if (last_acc) sent++;
        end
        drain(to);
        n_chk++; if (to || cnt_checked !== 4'd15 || cnt_passed !== 4'd15) begin n_err++; $display("FAIL sat_counters got %0d/%0d want 15/15", cnt_checked, cnt_passed); end
        n_chk++; if (first_fail_vld !== 1'b0) begin n_err++; $display("FAIL sat_no_fail got %b want 0", first_fail_vld); end
        in_valid = 1'b1; in_sample = rand_sample();
        tick();
        in_valid = 1'b0;
        tick();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        n_chk++; if (smp_out_valid !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL clr_xfer got %b/%b want 1/0", smp_out_valid, out_valid); end
        n_chk++; if (cnt_checked !== 4'd0 || cnt_passed !== 4'd0) begin n_err++; $display("FAIL clr_priority got %0d/%0d want 0/0", cnt_checked, cnt_passed); end
    endtask

    task automatic test_random();
        int p;
        bit to;
        obs_q.delete(); done_q.delete();
        for (int c = 0; c < 400; c++) begin
            cfg_we = ($urandom_range(0, 5) == 0);
            cfg_idx = 4'($urandom_range(0, 11));
            cfg_en = ($urandom_range(0, 2) != 0);
            cfg_op = 3'($urandom_range(0, 7));
            cfg_a = 4'($urandom_range(0, 9));
            cfg_b = 4'($urandom_range(0, 9));
            cfg_imm = ($urandom_range(0, 1) == 0) ? '0 : $urandom();
            in_valid = ($urandom_range(0, 3) != 0);
            in_sample = rand_sample();
            out_ready = ($urandom_range(0, 3) != 0);
            clr_stats = ($urandom_range(0, 49) == 0);
            p = pend_q.size();
            tick();
            n_chk++; if (smp_cfg_ready !== (p == 0)) begin n_err++; $display("FAIL rnd_cfg_ready c=%0d got %b want %b", c, smp_cfg_ready, p == 0); end
            n_chk++; if (smp_in_ready !== (p < 2 || out_ready)) begin n_err++; $display("FAIL rnd_in_ready c=%0d got %b want %b", c, smp_in_ready, p < 2 || out_ready); end
        end
        cfg_we = 1'b0; clr_stats = 1'b0;
        drain(to);
        n_chk++; if (to || obs_q.size() != done_q.size()) begin n_err++; $display("FAIL rnd_count got %0d want %0d", obs_q.size(), done_q.size()); end
        foreach (obs_q[i]) begin
            n_chk++; if (obs_q[i] !== done_q[i]) begin n_err++; $display("FAIL rnd_result[%0d] got %b want %b", i, obs_q[i], done_q[i]); end
        end
        n_chk++; if (cnt_checked !== 4'(m_chk) || cnt_passed !== 4'(m_pas)) begin n_err++; $display("FAIL rnd_counters got %0d/%0d want %0d/%0d", cnt_checked, cnt_passed, m_chk, m_pas); end
        n_chk++; if (first_fail_vld !== m_ffv) begin n_err++; $display("FAIL rnd_ff_vld got %b want %b", first_fail_vld, m_ffv); end
        if (m_ffv) begin
            n_chk++; if (first_fail_mask !== m_ffm || first_fail_seq !== 4'(m_ffs)) begin n_err++; $display("FAIL rnd_ff_record got %b/%0d want %b/%0d", first_fail_mask, first_fail_seq, m_ffm, m_ffs); end
        end
    endtask

    task automatic test_async_reset();
        logic [NV*VW-1:0] s;
        bit to;
        write_cfg(0, 1'b1, 4, 2, 3, '0);
        s = rand_sample(); s[2*VW +: VW] = '0;
        in_sample = s; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        tick();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_out_valid got %b want 0", out_valid); end
        n_chk++; if (in_ready !== 1'b1 || cfg_ready !== 1'b1) begin n_err++; $display("FAIL arst_ready got %b/%b want 1/1", in_ready, cfg_ready); end
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        out_ready = 1'b1;
        in_sample = s; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        drain(to);
        n_chk++; if (to || obs_q.size() != 1) begin n_err++; $display("FAIL arst_no_stale got %0d want 1", obs_q.size()); end
        n_chk++; if (obs_q[0] !== {1'b1, 10'b0}) begin n_err++; $display("FAIL arst_slots_cleared got %b want %b", obs_q[0], {1'b1, 10'b0}); end
        n_chk++; if (cnt_checked !== 4'd1) begin n_err++; $display("FAIL arst_cnt got %0d want 1", cnt_checked); end
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_op = '0; cfg_a = '0; cfg_b = '0;
        cfg_imm = '0; in_valid = 1'b0; in_sample = '0; out_ready = 1'b0; clr_stats = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_opcode();
        test_backpressure();
        test_cfg_gating();
        test_saturation();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of tests");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/constraint_check_pipe.md
Name: constraint_check_pipe

Overview:
- Parametrised, pipelined successor to the fixed combinational constraint checkers.
- Accepts packed sample vectors over a valid/ready handshake and evaluates NUM_CONS runtime-programmable constraints against them.
- Returns a per-sample pass bit and a fail mask, and keeps saturating pass/check statistics plus a sticky first-failure record.
- Sits between the sampler output and the scoreboard/coverage logic.

Parameters:
NUM_VARS, 10, number of sample variables in a packed sample
VAR_W, 32, width of each variable; all arithmetic is done at this width
NUM_CONS, 10, number of constraint slots
CNT_W, 32, width of the statistics counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cfg_we  in  1  constraint-slot write strobe
cfg_ready  out  1  high when a config write is accepted (pipeline empty)
cfg_idx  in  $clog2(NUM_CONS)  slot being written
cfg_en  in  1  slot enable
cfg_op  in  3  opcode
cfg_a  in  $clog2(NUM_VARS)  operand A variable index
cfg_b  in  $clog2(NUM_VARS)  operand B variable index
cfg_imm  in  VAR_W  immediate
in_valid  in  1  sample valid
in_ready  out  1  sample accepted when in_valid && in_ready
in_sample  in  NUM_VARS*VAR_W  packed sample, var i at [i*VAR_W +: VAR_W]
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_pass  out  1  AND of all enabled slot results
out_fail_mask  out  NUM_CONS  bit k=1 when enabled slot k failed
clr_stats  in  1  synchronous clear of counters and sticky record
cnt_checked  out  CNT_W  results delivered, saturating
cnt_passed  out  CNT_W  passing results delivered, saturating
first_fail_vld  out  1  sticky: a failure has been delivered
first_fail_mask  out  NUM_CONS  fail mask of the first failing result
first_fail_seq  out  CNT_W  cnt_checked value at that result (0-based)

Behaviour:
- The clock and reset are decided: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values:
  - all valids, counters, first_fail_* = 0.
  - every slot: op=7, en=0.
  - in_ready=1, cfg_ready=1.
- Slot result: r = f(A, B, imm), where A = var[cfg_a] and B = var[cfg_b]. The slot passes iff |r.
- Opcodes:
  - 0: A|B|imm
  - 1: (~A)^B
  - 2: A+B+imm, mod 2^VAR_W
  - 3: ~(A+B)
  - 4: (A!=0)&&(B!=0)
  - 5: (A!=B)&&(A!=0)
  - 6: A-B-imm, mod 2^VAR_W
  - 7: constant 1
- A disabled slot contributes mask bit 0 and does not affect out_pass. All slots disabled gives out_pass=1.
- Pipeline has 2 stages:
  - S1 registers operand selection for every slot.
  - S2 registers the computed fail mask and pass bit.
  - With out_ready held high, a sample accepted at edge N appears with out_valid at edge N+2.
  - Throughput is 1 sample per cycle.
- Backpressure:
  - S2 holds while out_valid && !out_ready.
  - S1 advances only if S2 is empty or draining.
  - in_ready = !S1_valid || S1_advances. No bubbles are inserted while the pipe is full and draining.
  - Outputs are stable while out_valid && !out_ready.
- Config:
  - cfg_ready = !S1_valid && !S2_valid. A write while cfg_ready=0 is ignored.
  - A write at edge N affects samples accepted at edge N+1 and later.
  - A write and a sample accept in the same cycle is allowed; the sample uses the old config.
  - cfg_idx >= NUM_CONS is ignored.
- Statistics update on each out_valid && out_ready:
  - cnt_checked += 1.
  - cnt_passed += out_pass.
  - Both saturate at all-ones.
  - On the first failing transfer with first_fail_vld=0: capture mask, capture seq = cnt_checked before the increment, set vld.
- clr_stats has priority over a same-cycle update: counters and sticky record go to 0, and that transfer is not counted. Pipeline contents are unaffected.
- Reset mid-operation discards in-flight samples and the config table.

Decomposition:
- Package constraint_check_pkg:
  - op_e enum: OP_OR, OP_XNOR, OP_ADD, OP_NADD, OP_LAND, OP_NEQ_LAND, OP_SUB, OP_TRUE.
  - slot_cfg_t struct {en, op, a_idx, b_idx, imm}.
  - OPC_W=3 constant.
- Sub-module constraint_slot_eval: combinational, takes (op, A, B, imm) and returns the pass bit. It is instantiated NUM_CONS times in S2.

Test Plan:
- Reset defaults: after reset, send one sample -> out_valid 2 cycles later, out_pass=1, mask=0, cnt_checked=1, cnt_passed=1.
- Opcode cases:
  - slot0 = OP_ADD, a=0, b=1, imm=0; var0=32'hFFFFFFFF, var1=1 -> sum wraps to 0, out_pass=0, mask=10'b1, first_fail_seq=0.
  - Same sample with var1=2 -> pass.
- Backpressure:
  - stream 5 samples with out_ready low for 3 cycles -> no loss or duplication, order preserved, in_ready low once both stages are full, cnt_checked=5.
- Config gating:
  - cfg_we while the pipe is non-empty -> ignored (cfg_ready=0).
  - cfg_we and in_valid in the same idle cycle -> that sample uses the old config, the next sample uses the new one.
- Saturation and clear:
  - CNT_W=4; send 20 passing samples -> cnt_checked=cnt_passed=15.
  - clr_stats concurrent with a transfer -> both 0 next cycle.
- Async reset mid-stream: assert rst with 2 samples in flight -> out_valid=0 immediately, no result emitted, slots back to disabled.
